dual_ram_pipe: RTL and testbench

- Parametrised simple dual-port synchronous RAM: one write port, one read port, single clock.
- Generalises the 256x8 dual-port RAM with:
  - byte-enable writes,
  - selectable read latency with a read-valid flag,
  - defined read-during-write behaviour,
  - a sequential init engine that sweeps memory to zero after reset or on request.
- Used as the storage core under FIFOs, line buffers and register files.

---
 rtl/dual_ram_pipe.sv | 158 +++++++++++++++
 tb/tb_dual_ram_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_ram_pipe.sv
// Simple dual-port synchronous RAM with byte enables,
// 1/2-cycle read latency and a zero-sweep init engine.
module dual_ram_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0,
   parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  we,
   input  logic [NUM_BYTES-1:0]  wr_be,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  init_busy
);

   typedef enum logic {INIT, RUN} state_e;

   localparam logic [ADDR_WIDTH:0] DEPTH_W =
      (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST =
      ADDR_WIDTH'(DEPTH - 1);
   localparam bit LAT2 = (RD_LATENCY == 2);
   localparam bit WR_FIRST = (RDW_MODE == 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  init_busy_q, init_busy_d;
   logic [DATA_WIDTH-1:0] s1_q, s1_d;
   logic                  s1_v_q, s1_v_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  run;
   logic                  wr_ok;
   logic                  rd_go;
   logic                  rd_in;
   logic                  collide;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NUM_BYTES-1:0]  mem_be;
   logic [DATA_WIDTH-1:0] src;
   logic                  src_v;

   assign run   = (state_q == RUN);
   assign wr_ok = run && we && ({1'b0, wr_addr} < DEPTH_W);
   assign rd_go = run && re;
   assign rd_in = ({1'b0, rd_addr} < DEPTH_W);

   // Array read path: bypass merged word on a write-first collision
   always_comb begin
      merged  = mem[wr_addr];
      for (int k = 0; k < NUM_BYTES; k++) begin
         if (wr_be[k]) merged[k*8 +: 8] = data_in[k*8 +: 8];
      end
      collide = WR_FIRST && wr_ok && (wr_addr == rd_addr);
      rd_word = '0;
      if (rd_in) rd_word = collide ? merged : mem[rd_addr];
   end

   // Write port mux: sweep writes zeros, RUN writes user bytes
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = data_in;
      mem_be    = wr_be;
      if (!rst) begin
         if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
            mem_be    = '1;
         end else begin
            mem_we = wr_ok;
         end
      end
   end

   // Byte-granular array write
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
         if (mem_we && mem_be[k])
            mem[mem_waddr][k*8 +: 8] <= mem_wdata[k*8 +: 8];
      end
   end

   // Sweep FSM next state; clear restarts the sweep from 0
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         INIT: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST) begin
               state_d = RUN;
               ptr_d   = '0;
            end
         end
         RUN: begin
            if (clear) begin
               state_d = INIT;
               ptr_d   = '0;
            end
         end
         default: state_d = INIT;
      endcase
      init_busy_d = (state_d == INIT);
   end

   // Read pipeline: optional array-output stage, then data_out
   always_comb begin
      s1_d       = rd_go ? rd_word : s1_q;
      s1_v_d     = rd_go;
      src        = LAT2 ? s1_q : rd_word;
      src_v      = LAT2 ? s1_v_q : rd_go;
      data_out_d = src_v ? src : data_out_q;
      rd_valid_d = src_v;
   end

   // State registers; rst discards in-flight reads
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         ptr_q       <= '0;
         init_busy_q <= 1'b1;
         s1_q        <= '0;
         s1_v_q      <= 1'b0;
         data_out_q  <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         init_busy_q <= init_busy_d;
         s1_q        <= s1_d;
         s1_v_q      <= s1_v_d;
         data_out_q  <= data_out_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   assign data_out  = data_out_q;
   assign rd_valid  = rd_valid_q;
   assign init_busy = init_busy_q;

endmodule

// File: tb/tb_dual_ram_pipe.sv
// Bench for dual_ram_pipe: three instances share stimulus.
// u0: lat1 read-first, u1: lat2 write-first, u2: DEPTH=12.
module tb_dual_ram_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  wr_be = 2'b00;
   logic [3:0]  wr_addr = 4'd0;
   logic [15:0] data_in = 16'd0;
   logic        re = 1'b0;
   logic [3:0]  rd_addr = 4'd0;

   logic [15:0] d0, d1, d2;
   logic        v0, v1, v2;
   logic        b0, b1, b2;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   dual_ram_pipe #(
      .DATA_WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4),
      .RD_LATENCY(1), .RDW_MODE(0)
   ) u0 (
      .clk(clk), .rst(rst), .clear(clear), .we(we),
      .wr_be(wr_be), .wr_addr(wr_addr),
      .data_in(data_in), .re(re), .rd_addr(rd_addr),
      .data_out(d0), .rd_valid(v0), .init_busy(b0)
   );

   dual_ram_pipe #(
      .DATA_WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4),
      .RD_LATENCY(2), .RDW_MODE(1)
   ) u1 (
      .clk(clk), .rst(rst), .clear(clear), .we(we),
      .wr_be(wr_be), .wr_addr(wr_addr),
      .data_in(data_in), .re(re), .rd_addr(rd_addr),
      .data_out(d1), .rd_valid(v1), .init_busy(b1)
   );

   dual_ram_pipe #(
      .DATA_WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4),
      .RD_LATENCY(1), .RDW_MODE(0)
   ) u2 (
      .clk(clk), .rst(rst), .clear(clear), .we(we),
      .wr_be(wr_be), .wr_addr(wr_addr),
      .data_in(data_in), .re(re), .rd_addr(rd_addr),
      .data_out(d2), .rd_valid(v2), .init_busy(b2)
   );

   typedef struct {
      logic        we;
      logic [1:0]  be;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic        re;
      logic [3:0]  ra;
      logic [15:0] exp0;
      logic [15:0] exp1;
   } vec_t;

   vec_t vt [20];

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", nm, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      we = 1'b0; re = 1'b0; clear = 1'b0; wr_be = 2'b00;
   endtask

   task automatic wr(input logic [3:0] a,
                     input logic [15:0] d,
                     input logic [1:0] be);
      we = 1'b1; wr_addr = a; data_in = d; wr_be = be;
      step();
      idle_in();
   endtask

   // One read; u0/u2 answer after 1 edge, u1 after 2
   task automatic rd_all(input logic [3:0] a,
                         input logic [15:0] e0,
                         input logic [15:0] e1,
                         input logic [15:0] e2);
      re = 1'b1; rd_addr = a;
      step();
      re = 1'b0;
      chk("rd_u0_valid", 32'(v0), 32'd1);
      chk("rd_u0_data", 32'(d0), 32'(e0));
      chk("rd_u2_valid", 32'(v2), 32'd1);
      chk("rd_u2_data", 32'(d2), 32'(e2));
      step();
      chk("rd_u0_valid_drop", 32'(v0), 32'd0);
      chk("rd_u1_valid", 32'(v1), 32'd1);
      chk("rd_u1_data", 32'(d1), 32'(e1));
   endtask

   // Counts busy cycles including the current sample
   task automatic wait_idle(output int c0,
                            output int c1,
                            output int c2);
      c0 = 0; c1 = 0; c2 = 0;
      for (int k = 0; k < 40; k++) begin
         if (!b0 && !b1 && !b2) break;
         if (b0) c0++;
         if (b1) c1++;
         if (b2) c2++;
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int c0, c1, c2;
      logic [15:0] hold0;

      vt[0]  = '{1, 2'b11, 3, 16'hABCD, 0, 0, 0, 0};
      vt[1]  = '{1, 2'b01, 3, 16'h1234, 0, 0, 0, 0};
      vt[2]  = '{0, 2'b00, 0, 16'h0000, 1, 3,
                 16'hAB34, 16'hAB34};
      vt[3]  = '{1, 2'b11, 1, 16'h0011, 0, 0, 0, 0};
      vt[4]  = '{1, 2'b11, 2, 16'h0022, 0, 0, 0, 0};
      vt[5]  = '{1, 2'b11, 3, 16'h0033, 0, 0, 0, 0};
      vt[6]  = '{1, 2'b11, 5, 16'h5555, 0, 0, 0, 0};
      vt[7]  = '{0, 2'b00, 0, 16'h0000, 1, 1,
                 16'h0011, 16'h0011};
      vt[8]  = '{0, 2'b00, 0, 16'h0000, 1, 2,
                 16'h0022, 16'h0022};
      vt[9]  = '{0, 2'b00, 0, 16'h0000, 1, 3,
                 16'h0033, 16'h0033};
      vt[10] = '{0, 2'b00, 0, 16'h0000, 0, 0, 0, 0};
      vt[11] = '{1, 2'b11, 5, 16'hAAAA, 1, 5,
                 16'h5555, 16'hAAAA};
      vt[12] = '{0, 2'b00, 0, 16'h0000, 1, 5,
                 16'hAAAA, 16'hAAAA};
      vt[13] = '{0, 2'b00, 0, 16'h0000, 0, 0, 0, 0};
      vt[14] = '{1, 2'b01, 5, 16'h00BB, 1, 5,
                 16'hAAAA, 16'hAABB};
      vt[15] = '{0, 2'b00, 0, 16'h0000, 1, 5,
                 16'hAABB, 16'hAABB};
      vt[16] = '{0, 2'b00, 0, 16'h0000, 0, 0, 0, 0};
      vt[17] = '{1, 2'b00, 5, 16'hFFFF, 0, 0, 0, 0};
      vt[18] = '{0, 2'b00, 0, 16'h0000, 1, 5,
                 16'hAABB, 16'hAABB};
      vt[19] = '{0, 2'b00, 0, 16'h0000, 0, 0, 0, 0};

      // Reset state
      step();
      step();
      chk("rst_busy0", 32'(b0), 32'd1);
      chk("rst_busy2", 32'(b2), 32'd1);
      chk("rst_valid0", 32'(v0), 32'd0);
      chk("rst_data0", 32'(d0), 32'd0);
      chk("rst_valid1", 32'(v1), 32'd0);
      rst = 1'b0;
      wait_idle(c0, c1, c2);
      chk("init_cycles_u0", 32'(c0), 32'd16);
      chk("init_cycles_u1", 32'(c1), 32'd16);
      chk("init_cycles_u2", 32'(c2), 32'd12);

      // Whole array reads back zero after the sweep
      for (int a = 0; a < 16; a++) begin
         re = 1'b1; rd_addr = 4'(a);
         step();
         chk("sweep_u0_valid", 32'(v0), 32'd1);
         chk("sweep_u0_data", 32'(d0), 32'd0);
         if (a > 0) begin
            chk("sweep_u1_valid", 32'(v1), 32'd1);
            chk("sweep_u1_data", 32'(d1), 32'd0);
         end
      end
      re = 1'b0;
      step();
      chk("sweep_u1_last_v", 32'(v1), 32'd1);
      chk("sweep_u1_last_d", 32'(d1), 32'd0);

      // Directed vectors: byte enables, latency, collisions
      hold0 = d0;
      for (int i = 0; i < 20; i++) begin
         we = vt[i].we; wr_be = vt[i].be;
         wr_addr = vt[i].wa; data_in = vt[i].wd;
         re = vt[i].re; rd_addr = vt[i].ra;
         step();
         if (vt[i].re) hold0 = vt[i].exp0;
         chk($sformatf("vec%0d_u0_valid", i),
             32'(v0), 32'(vt[i].re));
         chk($sformatf("vec%0d_u0_data", i),
             32'(d0), 32'(hold0));
         if (i > 0) begin
            chk($sformatf("vec%0d_u1_valid", i),
                32'(v1), 32'(vt[i-1].re));
            if (vt[i-1].re)
               chk($sformatf("vec%0d_u1_data", i),
                   32'(d1), 32'(vt[i-1].exp1));
         end
      end
      idle_in();

      // Clear with a same-cycle write and read
      clear = 1'b1;
      we = 1'b1; wr_addr = 4'd9; data_in = 16'h7777;
      wr_be = 2'b11;
      re = 1'b1; rd_addr = 4'd5;
      step();
      idle_in();
      chk("clr_u0_valid", 32'(v0), 32'd1);
      chk("clr_u0_data", 32'(d0), 32'hAABB);
      chk("clr_busy0", 32'(b0), 32'd1);
      // Traffic during the sweep is dropped
      we = 1'b1; wr_addr = 4'd4; data_in = 16'h1111;
      wr_be = 2'b11;
      re = 1'b1; rd_addr = 4'd4;
      step();
      idle_in();
      chk("clr_u1_inflight_v", 32'(v1), 32'd1);
      chk("clr_u1_inflight_d", 32'(d1), 32'hAABB);
      chk("clr_u0_drop_v", 32'(v0), 32'd0);
      wait_idle(c0, c1, c2);
      chk("clr_cycles_u0", 32'(c0 + 1), 32'd16);
      chk("clr_cycles_u1", 32'(c1 + 1), 32'd16);
      chk("clr_cycles_u2", 32'(c2 + 1), 32'd12);
      chk("clr_u1_drop_v", 32'(v1), 32'd0);
      rd_all(4'd9, 16'h0000, 16'h0000, 16'h0000);
      rd_all(4'd4, 16'h0000, 16'h0000, 16'h0000);

      // Out-of-range access on the 12-deep instance
      wr(4'd13, 16'hFFFF, 2'b11);
      rd_all(4'd13, 16'hFFFF, 16'hFFFF, 16'h0000);
      for (int a = 0; a < 12; a++) begin
         re = 1'b1; rd_addr = 4'(a);
         step();
         chk("oor_u2_valid", 32'(v2), 32'd1);
         chk("oor_u2_data", 32'(d2), 32'd0);
      end
      re = 1'b0;
      step();

      // rst discards an in-flight read
      re = 1'b1; rd_addr = 4'd13;
      step();
      re = 1'b0;
      rst = 1'b1;
      step();
      chk("rst_discard_v1", 32'(v1), 32'd0);
      chk("rst_discard_d1", 32'(d1), 32'd0);
      rst = 1'b0;

      // rst mid-sweep restarts it from 0
      for (int k = 0; k < 5; k++) step();
      chk("mid_busy2", 32'(b2), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_idle(c0, c1, c2);
      chk("mid_cycles_u0", 32'(c0), 32'd16);
      chk("mid_cycles_u2", 32'(c2), 32'd12);
      rd_all(4'd13, 16'h0000, 16'h0000, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
